// File: rtl/mux_nx1_rr.sv
// Registered N:1 valid/ready mux with fixed-select or round-robin arbitration; 1-cycle latency.
// A full output register holds under backpressure; in_ready_o is all-zero while stalled or in reset.
module mux_nx1_rr #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 mode_i,
    input  logic [SELW-1:0]      sel_i,
    input  logic [N-1:0]         in_valid_i,
    input  logic [N*WIDTH-1:0]   in_data_i,
    output logic [N-1:0]         in_ready_o,
    output logic                 out_valid_o,
    output logic [WIDTH-1:0]     out_data_o,
    output logic [SELW-1:0]      out_ch_o,
    input  logic                 out_ready_i
);

    localparam logic [SELW:0]   NUM_CH  = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [SELW-1:0]   out_ch_q,    out_ch_d;
    logic [SELW-1:0]   ptr_q,       ptr_d;

    logic              load_en;
    logic              rr_found;
    logic [SELW-1:0]   rr_idx;
    logic [SELW:0]     scan_idx;
    logic              cand_vld;
    logic [SELW-1:0]   cand;
    logic [WIDTH-1:0]  cand_dat;
    logic [N-1:0]      in_ready;
    logic              xfer;

    assign load_en = !out_valid_q || out_ready_i;

    // Scan from ptr upward with wrap at N (not 2^SELW); ptr is always < N.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = {1'b0, ptr_q} + (SELW+1)'(k);
            if (scan_idx >= NUM_CH) begin
                scan_idx = scan_idx - NUM_CH;
            end
            if (!rr_found && in_valid_i[scan_idx[SELW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = scan_idx[SELW-1:0];
            end
        end
    end

    always_comb begin
        cand     = '0;
        cand_vld = 1'b0;
        if (mode_i) begin
            cand     = rr_idx;
            cand_vld = rr_found;
        end else begin
            cand     = sel_i;
            cand_vld = ({1'b0, sel_i} < NUM_CH);
        end
    end

    always_comb begin
        in_ready = '0;
        cand_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (SELW'(i) == cand) begin
                in_ready[i] = rst_ni && load_en && cand_vld;
                cand_dat    = in_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer       = |(in_valid_i & in_ready);
    assign in_ready_o = in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = cand_dat;
            out_ch_d    = cand;
            if (mode_i) begin
                ptr_d = (cand == LAST_CH) ? '0 : cand + SELW'(1);
            end
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr: a 4-channel scoreboarded instance plus a 3-channel instance for non-power-of-2 cases.
module tb_mux_nx1_rr;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mode;
    logic [1:0]   sel;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_ch;
    logic         out_ready;

    logic         mode3;
    logic [1:0]   sel3;
    logic [2:0]   in_valid3;
    logic [95:0]  in_data3;
    logic [2:0]   in_ready3;
    logic         out_valid3;
    logic [31:0]  out_data3;
    logic [1:0]   out_ch3;
    logic         out_ready3;

    int checks = 0;
    int errors = 0;
    logic [33:0] sb_q[$];

    always #5 clk = ~clk;

    mux_nx1_rr #(.WIDTH(32), .N(4), .SELW(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .sel_i(sel),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_ch_o(out_ch),
        .out_ready_i(out_ready)
    );

    mux_nx1_rr #(.WIDTH(32), .N(3), .SELW(2)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode3), .sel_i(sel3),
        .in_valid_i(in_valid3), .in_data_i(in_data3), .in_ready_o(in_ready3),
        .out_valid_o(out_valid3), .out_data_o(out_data3), .out_ch_o(out_ch3),
        .out_ready_i(out_ready3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_xfer(input logic [1:0] ch, input logic [31:0] dat);
        sb_q.push_back({ch, dat});
    endtask

    task automatic n3_idle();
        chk("n3_in_ready_sel3", {61'd0, in_ready3}, 64'd0);
        chk("n3_out_valid_sel3", {63'd0, out_valid3}, 64'd0);
    endtask

    // Monitor: every word the consumer takes must be the next expected one.
    initial begin
        logic [33:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got ch %0d data 0x%0h, expected no output", out_ch, out_data);
                end else begin
                    exp = sb_q.pop_front();
                    chk("sb_ch", {62'd0, out_ch}, {62'd0, exp[33:32]});
                    chk("sb_data", {32'd0, out_data}, {32'd0, exp[31:0]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
        in_valid = 4'b0011; in_data = '0;
        in_data[0*32 +: 32] = 32'h0000_0000;
        in_data[1*32 +: 32] = 32'hFFFF_FFFF;
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        in_data3 = {32'h32, 32'h31, 32'h30};

        // Reset held for two edges
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_out_data", {32'd0, out_data}, 64'd0);
            chk("rst_in_ready", {60'd0, in_ready}, 64'd0);
        end
        rst_n = 1'b1;

        // Fixed select, channel 0 then channel 1
        for (int i = 0; i < 10; i++) begin
            expect_xfer(2'd0, 32'h0000_0000);
            cyc();
            if (i == 0) begin
                chk("fix0_valid", {63'd0, out_valid}, 64'd1);
                chk("fix0_ch", {62'd0, out_ch}, 64'd0);
            end
        end
        sel = 2'd1;
        for (int i = 0; i < 4; i++) begin
            expect_xfer(2'd1, 32'hFFFF_FFFF);
            cyc();
            if (i == 0) begin
                chk("fix1_data", {32'd0, out_data}, 64'hFFFF_FFFF);
                chk("fix1_ch", {62'd0, out_ch}, 64'd1);
            end
        end

        // Backpressure on channel 2
        sel = 2'd2; in_valid = 4'b0111;
        in_data[2*32 +: 32] = 32'hA5A5_A5A5;
        expect_xfer(2'd2, 32'hA5A5_A5A5);
        cyc();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_data", {32'd0, out_data}, 64'hA5A5_A5A5);
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_in_ready", {60'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", {60'd0, in_ready}, 64'b0100);
        expect_xfer(2'd2, 32'hA5A5_A5A5);
        cyc();

        // Round-robin with all channels valid
        mode = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'h10 + 32'(i);
        for (int k = 0; k < 8; k++) begin
            expect_xfer(2'(k % 4), 32'h10 + 32'(k % 4));
            cyc();
            n3_idle();
        end

        // Move ptr to 3, then only channels 1 and 3 valid
        in_valid = 4'b0100;
        expect_xfer(2'd2, 32'h12);
        cyc();
        in_valid = 4'b1010;
        expect_xfer(2'd3, 32'h13); cyc();
        expect_xfer(2'd1, 32'h11); cyc();
        expect_xfer(2'd3, 32'h13); cyc();
        expect_xfer(2'd1, 32'h11); cyc();

        // Drain, then fill with a word that the reset will discard
        in_valid = 4'b0000;
        cyc();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);
        mode = 1'b0; sel = 2'd0; out_ready = 1'b0;
        in_data[0*32 +: 32] = 32'hDEAD_BEEF; in_valid = 4'b0001;
        cyc();
        chk("full_data", {32'd0, out_data}, 64'hDEAD_BEEF);
        chk("full_valid", {63'd0, out_valid}, 64'd1);
        in_valid = 4'b0000; rst_n = 1'b0;
        cyc();
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_data", {32'd0, out_data}, 64'd0);
        chk("midrst_ch", {62'd0, out_ch}, 64'd0);
        rst_n = 1'b1; mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'h20 + 32'(i);
        expect_xfer(2'd0, 32'h20);
        cyc();
        chk("postrst_ch", {62'd0, out_ch}, 64'd0);
        expect_xfer(2'd1, 32'h21);
        cyc();
        in_valid = 4'b0000;
        cyc();
        cyc();
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        // Three-channel instance: valid select, then round-robin wrap mod 3
        n3_idle();
        sel3 = 2'd2;
        #1;
        chk("n3_in_ready_sel2", {61'd0, in_ready3}, 64'b100);
        cyc();
        chk("n3_out_valid", {63'd0, out_valid3}, 64'd1);
        chk("n3_out_data", {32'd0, out_data3}, 64'h32);
        chk("n3_out_ch", {62'd0, out_ch3}, 64'd2);
        mode3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("n3_rr_ch", {62'd0, out_ch3}, 64'(k % 3));
            chk("n3_rr_data", {32'd0, out_data3}, 64'h30 + 64'(k % 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
